// File: rtl/pi_pkg.sv
// pi_pkg -- shared definitions for the PI channel scheduler.
//   PI_WIDTH     : default operand/result width
//   PI_LAT       : default pi core latency (pi_start to valid pi_uk)
//   pi_state_t   : scheduler FSM state encoding (3 bits)
package pi_pkg;

    localparam int unsigned PI_WIDTH = 32;
    localparam int unsigned PI_LAT   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4
    } pi_state_t;

endpackage

// File: rtl/rr_arb.sv
// rr_arb -- combinational round-robin arbiter.
//   req        : per-channel request vector
//   last_grant : index of the most recently served channel
//   gnt        : lowest requesting index strictly after last_grant (wrapping)
//   valid      : at least one request present
module rr_arb #(
    parameter int unsigned NCH = 4,
    parameter int unsigned GW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [GW-1:0]  last_grant,
    output logic [GW-1:0]  gnt,
    output logic           valid
);

    logic [GW-1:0] hi_idx;
    logic [GW-1:0] lo_idx;
    logic          hi_v;
    logic          lo_v;

    // Two candidates: first requester above last_grant, and first requester
    // at or below it (the wrap-around case). The upper one has priority.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_v   = 1'b0;
        lo_v   = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (req[k]) begin
                if (GW'(k) > last_grant) begin
                    if (!hi_v) begin
                        hi_idx = GW'(k);
                        hi_v   = 1'b1;
                    end
                end else if (!lo_v) begin
                    lo_idx = GW'(k);
                    lo_v   = 1'b1;
                end
            end
        end
        gnt   = hi_v ? hi_idx : lo_idx;
        valid = hi_v | lo_v;
    end

endmodule

// File: rtl/pi_sched.sv
// pi_sched -- time-multiplexes one external PI core across NCH channels.
// Optional feature macro: PI_SCHED_STAT_EN (adds per-channel svc_cnt counters).
//   req            : per-channel level request, held until its done pulse
//   ek, kp, ki     : per-channel error and gains, channel i at [i*WIDTH +: WIDTH]
//   uk_min, uk_max : clamp limits, consumed by the external core only
//   pi_start       : one-cycle start pulse to the core
//   pi_uk_ex, pi_kp, pi_ki, pi_ek, pi_ek_ex : core operands, held ISSUE..STORE
//   pi_uk          : clamped core result, valid LAT cycles after pi_start
//   uk             : per-channel last stored result
//   done           : one-cycle pulse on the channel just serviced
//   busy           : high whenever the scheduler is not idle
//   svc_cnt        : (PI_SCHED_STAT_EN only) per-channel 16-bit service counters
module pi_sched
    import pi_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = PI_WIDTH,
    parameter int unsigned LAT   = PI_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] ek,
    input  logic [NCH*WIDTH-1:0] kp,
    input  logic [NCH*WIDTH-1:0] ki,
    input  logic [WIDTH-1:0]     uk_min,
    input  logic [WIDTH-1:0]     uk_max,
    output logic                 pi_start,
    output logic [WIDTH-1:0]     pi_uk_ex,
    output logic [WIDTH-1:0]     pi_kp,
    output logic [WIDTH-1:0]     pi_ki,
    output logic [WIDTH-1:0]     pi_ek,
    output logic [WIDTH-1:0]     pi_ek_ex,
    input  logic [WIDTH-1:0]     pi_uk,
    output logic [NCH*WIDTH-1:0] uk,
    output logic [NCH-1:0]       done,
`ifdef PI_SCHED_STAT_EN
    output logic [NCH*16-1:0]    svc_cnt,
`endif
    output logic                 busy
);

    localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    pi_state_t      state;
    pi_state_t      state_nxt;
    logic [GW-1:0]  gnt;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  arb_gnt;
    logic           arb_valid;
    logic [CW-1:0]  wait_cnt;
    logic [WIDTH-1:0] ek_snap;

    logic [WIDTH-1:0] uk_mem [NCH];
    logic [WIDTH-1:0] ek_mem [NCH];
    logic [WIDTH-1:0] ek_a   [NCH];
    logic [WIDTH-1:0] kp_a   [NCH];
    logic [WIDTH-1:0] ki_a   [NCH];

    // Limits go straight to the external core; no ordering check is made here.
    logic clamp_limits_unused;
    assign clamp_limits_unused = ^{uk_min, uk_max};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ek_a[i]                 = ek[i*WIDTH +: WIDTH];
        assign kp_a[i]                 = kp[i*WIDTH +: WIDTH];
        assign ki_a[i]                 = ki[i*WIDTH +: WIDTH];
        assign uk[i*WIDTH +: WIDTH]    = uk_mem[i];
    end

    rr_arb #(
        .NCH (NCH),
        .GW  (GW)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (arb_gnt),
        .valid      (arb_valid)
    );

    assign pi_ek    = ek_snap;
    assign pi_start = (state == ST_ISSUE);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|req) state_nxt = ST_ARB;
            // A request withdrawn before arbitration simply returns to idle.
            ST_ARB:   state_nxt = arb_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_cnt == CW'(LAT - 1)) state_nxt = ST_STORE;
            ST_STORE: state_nxt = |(req & ~(NCH'(1) << gnt)) ? ST_ARB : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            last_grant <= GW'(NCH - 1);
            wait_cnt   <= '0;
            done       <= '0;
            ek_snap    <= '0;
            pi_uk_ex   <= '0;
            pi_ek_ex   <= '0;
            pi_kp      <= '0;
            pi_ki      <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                uk_mem[i] <= '0;
                ek_mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            done  <= '0;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            // Operands are captured at grant time so they stay stable through
            // the whole service regardless of input changes.
            if (state == ST_ARB && arb_valid) begin
                gnt      <= arb_gnt;
                ek_snap  <= ek_a[arb_gnt];
                pi_uk_ex <= uk_mem[arb_gnt];
                pi_ek_ex <= ek_mem[arb_gnt];
                pi_kp    <= kp_a[arb_gnt];
                pi_ki    <= ki_a[arb_gnt];
            end
            if (state == ST_STORE) begin
                uk_mem[gnt] <= pi_uk;
                ek_mem[gnt] <= ek_snap;
                done[gnt]   <= 1'b1;
                last_grant  <= gnt;
            end
        end
    end

`ifdef PI_SCHED_STAT_EN
    logic [15:0] cnt_r [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        assign svc_cnt[i*16 +: 16] = cnt_r[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) cnt_r[i] <= '0;
        end else if (state == ST_STORE) begin
            cnt_r[gnt] <= cnt_r[gnt] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pi_sched.sv
// tb_pi_sched -- bench for pi_sched with an external PI core model and a
// service-level reference model. Define PI_SCHED_STAT_EN to cover svc_cnt.
module tb_pi_sched;

    localparam int NCH   = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] ek, kp, ki;
    logic [WIDTH-1:0]     uk_min, uk_max;
    logic                 pi_start;
    logic [WIDTH-1:0]     pi_uk_ex, pi_kp, pi_ki, pi_ek, pi_ek_ex;
    logic [WIDTH-1:0]     pi_uk = '0;
    logic [NCH*WIDTH-1:0] uk;
    logic [NCH-1:0]       done;
    logic                 busy;
`ifdef PI_SCHED_STAT_EN
    logic [NCH*16-1:0]    svc_cnt;
`endif

    pi_sched #(.NCH(NCH), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ek(ek), .kp(kp), .ki(ki),
        .uk_min(uk_min), .uk_max(uk_max), .pi_start(pi_start),
        .pi_uk_ex(pi_uk_ex), .pi_kp(pi_kp), .pi_ki(pi_ki), .pi_ek(pi_ek),
        .pi_ek_ex(pi_ek_ex), .pi_uk(pi_uk), .uk(uk), .done(done),
`ifdef PI_SCHED_STAT_EN
        .svc_cnt(svc_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // uk = uk_ex + kp*(ek - ek_ex) + ki*ek, clamped to [mn, mx] (signed).
    function automatic logic [WIDTH-1:0] pi_calc(input logic [WIDTH-1:0] a_ukex, a_kp, a_ki,
                                                 a_ek, a_ekex, mn, mx);
        logic signed [WIDTH-1:0] v;
        v = a_ukex + a_kp * (a_ek - a_ekex) + a_ki * a_ek;
        if (v > $signed(mx)) v = mx;
        if (v < $signed(mn)) v = mn;
        return v;
    endfunction

    // External core: garbage until LAT cycles after pi_start, then the result.
    logic [WIDTH-1:0] core_res;
    int core_k = 0;
    always @(posedge clk) begin
        if (pi_start) begin
            core_res = pi_calc(pi_uk_ex, pi_kp, pi_ki, pi_ek, pi_ek_ex, uk_min, uk_max);
            core_k   = LAT - 1;
            if (core_k == 0) pi_uk <= core_res;
            else             pi_uk <= 32'hDEAD_BEEF;
        end else if (core_k > 0) begin
            core_k--;
            if (core_k == 0) pi_uk <= core_res;
        end
    end

    // Service-level reference model. A service occupies LAT+3 cycles
    // (age 0 = arbitration .. age LAT+2 = store); results land when it ends.
    int               m_age = -1;
    int               m_ch, m_last;
    bit               m_started = 1'b0;
    logic [WIDTH-1:0] m_uk [NCH];
    logic [WIDTH-1:0] m_ek [NCH];
    logic [WIDTH-1:0] m_op_ukex, m_op_ekex, m_op_ek, m_op_kp, m_op_ki, m_res;
    logic [NCH-1:0]   m_done;
    int               m_cnt [NCH];

    function automatic int pick(input logic [NCH-1:0] r, input int last);
        for (int k = 1; k <= NCH; k++)
            if (r[(last + k) % NCH]) return (last + k) % NCH;
        return -1;
    endfunction

    always @(posedge clk) begin
        int c;
        if (!rst_n) begin
            m_started = 1'b1;
            m_age = -1; m_last = NCH - 1; m_ch = 0; m_done = '0;
            m_op_ukex = '0; m_op_ekex = '0; m_op_ek = '0; m_op_kp = '0; m_op_ki = '0;
            for (int i = 0; i < NCH; i++) begin m_uk[i] = '0; m_ek[i] = '0; m_cnt[i] = 0; end
        end else begin
            m_done = '0;
            if (m_age < 0) begin
                if (req != '0) m_age = 0;
            end else if (m_age == 0) begin
                c = pick(req, m_last);
                if (c < 0) m_age = -1;
                else begin
                    m_ch      = c;
                    m_op_ukex = m_uk[c];
                    m_op_ekex = m_ek[c];
                    m_op_ek   = ek[c*WIDTH +: WIDTH];
                    m_op_kp   = kp[c*WIDTH +: WIDTH];
                    m_op_ki   = ki[c*WIDTH +: WIDTH];
                    m_res     = pi_calc(m_op_ukex, m_op_kp, m_op_ki, m_op_ek, m_op_ekex, uk_min, uk_max);
                    m_age     = 1;
                end
            end else if (m_age < LAT + 2) begin
                m_age++;
            end else begin
                m_uk[m_ch]   = m_res;
                m_ek[m_ch]   = m_op_ek;
                m_done[m_ch] = 1'b1;
                m_last       = m_ch;
                m_cnt[m_ch]  = (m_cnt[m_ch] + 1) % 65536;
                m_age        = ((req & ~(NCH'(1) << m_ch)) != '0) ? 0 : -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [NCH*WIDTH-1:0] exp_uk;
        if (m_started) begin
            for (int i = 0; i < NCH; i++) exp_uk[i*WIDTH +: WIDTH] = m_uk[i];
            chk("busy", busy, m_age >= 0);
            chk("pi_start", pi_start, m_age == 1);
            chk("done", done, m_done);
            chk("uk", uk, exp_uk);
            chk("operands", {pi_uk_ex, pi_ek_ex, pi_ek, pi_kp, pi_ki},
                {m_op_ukex, m_op_ekex, m_op_ek, m_op_kp, m_op_ki});
`ifdef PI_SCHED_STAT_EN
            for (int i = 0; i < NCH; i++)
                chk("svc_cnt", svc_cnt[i*16 +: 16], 16'(m_cnt[i]));
`endif
        end
    end

    task automatic set_ch(input int c, input int e, input int p, input int i);
        ek[c*WIDTH +: WIDTH] = 32'(e);
        kp[c*WIDTH +: WIDTH] = 32'(p);
        ki[c*WIDTH +: WIDTH] = 32'(i);
    endtask

    task automatic wait_done(input int maxc, output int idx, output int bidx, output logic [NCH-1:0] d);
        idx = -1; bidx = -1; d = '0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (busy && bidx < 0) bidx = i;
            if (done != '0) begin idx = i; d = done; break; end
        end
        chk("done_seen", idx >= 0, 1'b1);
    endtask

    task automatic wait_start(input int maxc);
        int seen = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (pi_start) begin seen = 1; break; end
        end
        chk("start_seen", seen, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        int idx, bidx, acc;
        logic [NCH-1:0] d;
        rst_n = 1'b0; req = '0; ek = '0; kp = '0; ki = '0;
        uk_min = 32'(-1000); uk_max = 32'(1000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_uk", uk, '0);
        chk("rst_done", done, '0);
        chk("rst_start", pi_start, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single request, first pass: 0 + 2*(10-0) + 1*10 = 30.
        @(posedge clk); #1 set_ch(0, 10, 2, 1); req = 4'b0001;
        wait_done(40, idx, bidx, d);
        chk("lat", idx - bidx, LAT + 3);
        chk("t1_done", d, 4'b0001);
        chk("t1_uk", uk[WIDTH-1:0], 32'd30);
        chk("t1_core", pi_uk, 32'd30);

        // Second pass, req held: 30 + 2*(10-10) + 1*10 = 40.
        wait_start(20);
        chk("t2_ekex", pi_ek_ex, 32'd10);
        chk("t2_ukex", pi_uk_ex, 32'd30);
        wait_done(40, idx, bidx, d);
        chk("t2_uk", uk[WIDTH-1:0], 32'd40);
        req = '0;

        // Reset during WAIT discards the service and restores channel-0 priority.
        @(posedge clk); #1 req = 4'b0001;
        wait_start(20);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; req = '0;
        acc = 0;
        for (int i = 0; i < LAT + 4; i++) begin @(negedge clk); acc = acc | int'(done); end
        chk("rst_nodone", acc, 0);
        chk("rst_uk0", uk, '0);

        // Fairness: all four requesting, eight back-to-back services.
        for (int c = 0; c < NCH; c++) set_ch(c, c + 3, 1, 2);
        req = 4'b1111;
        for (int s = 0; s < 8; s++) begin
            logic [NCH-1:0] e;
            e = NCH'(1) << (s % NCH);
            wait_done(40, idx, bidx, d);
            chk("rr_order", d, e);
            if (s > 0) chk("rr_gap", idx, LAT + 2);
        end
        req = '0;
        repeat (LAT + 4) @(posedge clk);

        // Clamp: 30 limited to 25.
        pulse_reset();
        uk_max = 32'd25; set_ch(0, 10, 2, 1); req = 4'b0001;
        wait_done(40, idx, bidx, d);
        chk("clamp_uk", uk[WIDTH-1:0], 32'd25);
        req = '0; uk_max = 32'd1000;
        repeat (LAT + 4) @(posedge clk);

`ifdef PI_SCHED_STAT_EN
        pulse_reset();
        set_ch(2, 5, 1, 1); req = 4'b0100;
        for (int s = 0; s < 3; s++) wait_done(40, idx, bidx, d);
        req = '0;
        chk("stat_c2", svc_cnt[2*16 +: 16], 16'd3);
        chk("stat_other", {svc_cnt[3*16 +: 16], svc_cnt[0 +: 32]}, '0);
        repeat (LAT + 4) @(posedge clk);
`endif

        // Randomized traffic against the reference model.
        pulse_reset();
        uk_min = 32'(-int'($urandom_range(0, 500)));
        uk_max = 32'($urandom_range(0, 500));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 599) != 0);
            for (int c = 0; c < NCH; c++) begin
                if (done[c]) req[c] = 1'b0;
                else if (!req[c] && $urandom_range(0, 3) == 0) req[c] = 1'b1;
                else if (req[c] && $urandom_range(0, 63) == 0) req[c] = 1'b0;
                if ($urandom_range(0, 2) == 0)
                    set_ch(c, int'($urandom_range(0, 200)) - 100,
                           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end
        end
        req = '0; rst_n = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pi_sched.md
PI_SCHED -- requirements
Module: pi_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of PI channels sharing one pi core.
REQ-002 SHALL have parameter WIDTH, default 32, meaning the data width of every operand and result.
REQ-003 SHALL have parameter LAT, default 4, meaning the cycles from a pi_start pulse to a valid pi_uk.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-006 SHALL have port req, input, NCH bits: a per-channel level request that is held until the matching done pulse.
REQ-007 SHALL have port ek, input, NCH*WIDTH bits: per-channel current error, with channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have ports kp and ki, input, NCH*WIDTH bits each: per-channel gains.
REQ-009 SHALL have ports uk_min and uk_max, input, WIDTH bits each: shared output clamp limits.
REQ-010 SHALL have port pi_start, output, 1 bit: a one-cycle start pulse to the pi core.
REQ-011 SHALL have ports pi_uk_ex, pi_kp, pi_ki, pi_ek and pi_ek_ex, output, WIDTH bits each: operands to the pi core.
REQ-012 SHALL have port pi_uk, input, WIDTH bits: the clamped pi core result.
REQ-013 SHALL have port uk, output, NCH*WIDTH bits: the per-channel last stored result.
REQ-014 SHALL have port done, output, NCH bits: a one-cycle pulse on the channel just serviced.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ARB, ISSUE, WAIT and STORE.
REQ-017 IDLE SHALL go to ARB when |req is high; otherwise it SHALL stay in IDLE.
REQ-018 ARB SHALL grant round-robin: the lowest requesting index strictly after last_grant, wrapping from NCH-1 to 0; it SHALL latch gnt, latch ek[gnt] into an ek snapshot, then go to ISSUE.
REQ-019 ISSUE SHALL drive pi_start=1 for exactly one cycle, with operands pi_uk_ex=uk_mem[gnt], pi_ek_ex=ek_mem[gnt], pi_ek=snapshot, pi_kp=kp[gnt] and pi_ki=ki[gnt]; it SHALL then go to WAIT.
REQ-020 Operands SHALL be held stable from ISSUE through STORE; outside these states pi_start SHALL be 0.
REQ-021 WAIT SHALL count LAT cycles and then go to STORE.
REQ-022 STORE SHALL perform uk_mem[gnt]<=pi_uk, ek_mem[gnt]<=snapshot, done[gnt]<=1 for one cycle and last_grant<=gnt, then go to ARB if any other req bit is set, otherwise to IDLE.
REQ-023 Per-grant latency SHALL be ARB 1 + ISSUE 1 + WAIT LAT + STORE 1 = LAT+3 cycles.
REQ-024 A req that drops mid-service SHALL NOT abort the service; the result is stored and done still pulses.
REQ-025 Simultaneous requests SHALL be served in rotation, never twice in a row while another channel is requesting.
REQ-026 uk_min > uk_max SHALL NOT be checked; the values pass through to the core unchanged.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL enter IDLE with gnt=0, last_grant=NCH-1 (so channel 0 wins first), all uk_mem and ek_mem entries 0, uk=0, done=0, pi_start=0, busy=0 and all operand outputs 0.
REQ-028 Reset mid-service SHALL discard the in-flight result and no done SHALL pulse for it.

Configuration
REQ-029 With macro PI_SCHED_STAT_EN defined, the block SHALL add an output svc_cnt, NCH*16 bits, holding per-channel 16-bit counters that increment on each done, wrap at 0xFFFF to 0 and clear on reset.
REQ-030 Without PI_SCHED_STAT_EN, svc_cnt and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package pi_pkg SHALL hold the FSM state encoding constants (3 bits) and the default WIDTH and LAT.
REQ-032 The round-robin arbiter SHALL be one sub-module, rr_arb, with inputs req and last_grant and outputs gnt index and valid.
REQ-033 The pi core SHALL be instantiated outside this block.

Verification
REQ-034 Single request: req=0001, ek0=10, kp0=2, ki0=1, with a core model giving uk_ex+kp*(ek-ek_ex)+ki*ek; pi_uk=30 SHALL appear, done[0] SHALL pulse at cycle LAT+3 and uk[0]=30.
REQ-035 Second pass: hold req0 with ek0=10; pi_ek_ex SHALL be 10, pi_uk_ex SHALL be 30 and uk[0]=40.
REQ-036 Fairness: req=1111 held for 8 services; the grant order SHALL be 0,1,2,3,0,1,2,3 with no idle cycles between services.
REQ-037 Clamp: uk_max=25 with the case of REQ-034; uk[0]=25 SHALL be stored.
REQ-038 Reset in WAIT: assert rst_n=0 one cycle; done SHALL stay 0, uk SHALL be all 0 and the next grant SHALL be channel 0.
REQ-039 Under PI_SCHED_STAT_EN: after 3 services of channel 2, svc_cnt[2] SHALL be 3 and the other counters 0.
